// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown16 timer family: FSM states, widths,
// and the counter reset value.
package countdown_pkg;

  localparam int COUNT_W = 16;
  localparam int PRE_W   = 8;

  localparam logic [COUNT_W-1:0] COUNT_RST = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // States in which the timer is considered active.
  function automatic logic is_busy(input state_e s);
    return (s == ST_LOAD) || (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/countdown16_core.sv
// Down-counter datapath: parallel load has priority over decrement.
// No sequencing here; the controller decides when to load or step.
module countdown16_core #(
  parameter int WIDTH = countdown_pkg::COUNT_W
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec_en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: load wins over decrement, otherwise hold.
  always_comb begin
    count_d = count_q;
    if (load)        count_d = load_val;
    else if (dec_en) count_d = count_q - ONE;
  end

  // Counter register, negedge with synchronous reset to all-ones.
  always_ff @(negedge clock0) begin
    if (reset) count_q <= '1;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/countdown16_timer_ctrl.sv
// Programmable timer controller: FSM, prescaler and irq around one
// countdown16_core. Everything updates on the falling edge of clock0.
module countdown16_timer_ctrl #(
  parameter int WIDTH = countdown_pkg::COUNT_W,
  parameter int PRE_W = countdown_pkg::PRE_W
) (
  input  logic             clock0,
  input  logic             reset,
  input  logic [WIDTH-1:0] cfg_load_val,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic [2:0]       state,
  output logic             busy,
  output logic             expired,
  output logic             irq
);

  import countdown_pkg::*;

  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  state_e           state_q;
  logic [PRE_W-1:0] pre_q;
  logic             busy_q, exp_q, irq_q;

  logic [WIDTH-1:0] count_w;
  logic             tick, run_act, cnt_zero, expire;
  logic             core_load, core_dec;

  // Decode this edge's counting action. Counting happens only in RUN with
  // no higher-priority control asserted, so a retrigger or pause swallows
  // any pending tick or expiry.
  always_comb begin
    tick      = (pre_q == '0);
    cnt_zero  = (count_w == '0);
    run_act   = (state_q == ST_RUN) && !stop && !start && !pause;
    expire    = run_act && tick && cnt_zero;
    core_load = ((state_q == ST_LOAD) && !stop) || (expire && cfg_periodic);
    core_dec  = run_act && tick && !cnt_zero;
  end

  countdown16_core #(.WIDTH(WIDTH)) u_core (
    .clock0   (clock0),
    .reset    (reset),
    .load     (core_load),
    .load_val (cfg_load_val),
    .dec_en   (core_dec),
    .count    (count_w)
  );

  // FSM with prescaler, expiry pulse and sticky irq; priority reset, stop,
  // start, pause.
  always_ff @(negedge clock0) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      busy_q  <= 1'b0;
      exp_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      exp_q <= expire;
      if (expire)       irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;

      if (stop) begin
        state_q <= ST_IDLE;
        pre_q   <= '0;
        busy_q  <= 1'b0;
      end else if (start) begin
        // A start seen while already in LOAD still performs the load.
        if (state_q == ST_LOAD) pre_q <= cfg_prescale;
        state_q <= ST_LOAD;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_LOAD: begin
            pre_q   <= cfg_prescale;
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_PAUSE;
            end else if (tick) begin
              pre_q <= cfg_prescale;
              if (cnt_zero && !cfg_periodic) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
              end
            end else begin
              pre_q <= pre_q - PRE_ONE;
            end
          end
          ST_PAUSE: if (!pause) state_q <= ST_RUN;
          ST_DONE: ;
          default: begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count   = count_w;
  assign state   = state_q;
  assign busy    = busy_q;
  assign expired = exp_q;
  assign irq     = irq_q;

endmodule
